// File: rtl/dp_ram_burst_reader_pkg.sv
// Shared definitions for the burst reader: FSM state encoding and skid FIFO sizing.
package dp_ram_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } reader_state_t;

   localparam int SKID_DEPTH = 2;
   localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
   localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO that soaks up RAM read data while the downstream stream is stalled.
module stream_skid_fifo
   import dp_ram_burst_reader_pkg::*;
#(
   parameter int WIDTH = 65
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_push_data,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_head_data,
   output logic [SKID_CNT_W-1:0] o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   logic [WIDTH-1:0]      r_mem [SKID_DEPTH];
   logic [SKID_PTR_W-1:0] r_wr_ptr;
   logic [SKID_PTR_W-1:0] r_rd_ptr;
   logic [SKID_CNT_W-1:0] r_count;
   logic                  w_pop;
   logic                  w_push;

   // A push onto a full FIFO is only legal when the head leaves in the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + SKID_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + SKID_PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + SKID_CNT_W'(1);
            2'b01:   r_count <= r_count - SKID_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_data = r_mem[r_rd_ptr];
   assign o_count     = r_count;
   assign o_full      = (r_count == SKID_CNT_W'(SKID_DEPTH));
   assign o_empty     = (r_count == '0);

endmodule

// File: rtl/dp_ram_burst_reader.sv
// Burst read master for the dual-port block RAM: issues port-B reads under a credit
// limit and streams the returned words out as valid/ready with a last marker.
module dp_ram_burst_reader
   import dp_ram_burst_reader_pkg::*;
#(
   parameter int RAM_DEPTH  = 16,
   parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [LEN_WIDTH-1:0]  i_cmd_len,
   output logic                  o_ram_enb,
   output logic [ADDR_WIDTH-1:0] o_ram_addrb,
   input  logic [DATA_WIDTH-1:0] i_ram_dob,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_last,
   output logic                  o_busy,
   output logic                  o_done
);

   reader_state_t         r_state;
   reader_state_t         w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_issued;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_pop;
   logic                  w_out_valid;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [SKID_CNT_W-1:0] w_fifo_count;
   logic [2:0]            w_occupancy;
   logic [DATA_WIDTH:0]   w_head;

   assign w_out_valid = !w_fifo_empty;
   assign w_pop       = w_out_valid && i_out_ready;

   // Never let FIFO plus in-flight exceed the skid depth, so captured data always has a slot.
   assign w_occupancy  = 3'(w_fifo_count) + 3'(r_inflight);
   assign w_issue      = (r_state == ST_RUN) && (r_issued < r_len) &&
                         (w_occupancy < (3'(SKID_DEPTH) + 3'(w_pop)));
   assign w_last_issue = w_issue && (r_issued == (r_len - LEN_WIDTH'(1)));

   // Explicit wrap compare keeps non-power-of-two depths correct.
   assign w_next_addr = (r_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                                : r_addr + ADDR_WIDTH'(1);

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (i_cmd_valid) begin
               w_next_state = (i_cmd_len == '0) ? ST_FINISH : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last_issue) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_fifo_empty && !r_inflight) begin
               w_next_state = ST_FINISH;
            end
         end
         ST_FINISH: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr          <= '0;
         r_len           <= '0;
         r_issued        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && i_cmd_valid) begin
            r_addr   <= i_cmd_addr;
            r_len    <= i_cmd_len;
            r_issued <= '0;
         end else if (w_issue) begin
            r_addr   <= w_next_addr;
            r_issued <= r_issued + LEN_WIDTH'(1);
         end
         r_inflight      <= w_issue;
         r_inflight_last <= w_last_issue;
      end
   end

   stream_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_skid_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (r_inflight),
      .i_push_data ({r_inflight_last, i_ram_dob}),
      .i_pop       (w_pop),
      .o_head_data (w_head),
      .o_count     (w_fifo_count),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_ram_enb   = w_issue;
   assign o_ram_addrb = r_addr;
   assign o_out_valid = w_out_valid;
   assign o_out_data  = w_head[DATA_WIDTH-1:0];
   assign o_out_last  = w_head[DATA_WIDTH];
   assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign o_done      = (r_state == ST_FINISH);

endmodule

// File: tb/tb_dp_ram_burst_reader.sv
// Scoreboard bench for dp_ram_burst_reader: stimulus queues expected reads and words,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dp_ram_burst_reader;

   localparam int RAM_DEPTH  = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int DATA_WIDTH = 64;
   localparam int LEN_WIDTH  = 5;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  ram_enb;
   logic [ADDR_WIDTH-1:0] ram_addrb;
   logic [DATA_WIDTH-1:0] ram_dob = '0;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   logic [DATA_WIDTH-1:0] ramMem [RAM_DEPTH];

   int assertCount = 0;
   int failCount   = 0;
   int cycleCount  = 0;
   int acceptCount = 0;
   int doneCount   = 0;
   int enbCount    = 0;
   int popCount    = 0;
   int outstanding = 0;
   logic                  stalled = 1'b0;
   logic [DATA_WIDTH-1:0] heldData = '0;
   logic                  heldLast = 1'b0;

   logic [DATA_WIDTH:0]   expWordQ [$];
   logic [ADDR_WIDTH-1:0] expAddrQ [$];
   int                    popCycleQ [$];

   logic bpMode = 1'b0;
   int   bpIdx  = 0;
   logic [5:0] bpPattern = 6'b101001;

   always #5 clk = ~clk;

   dp_ram_burst_reader #(
      .RAM_DEPTH  (RAM_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_addr  (cmd_addr),
      .i_cmd_len   (cmd_len),
      .o_ram_enb   (ram_enb),
      .o_ram_addrb (ram_addrb),
      .i_ram_dob   (ram_dob),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .o_busy      (busy),
      .o_done      (done)
   );

   // Behavioural port B: registered, enable-gated read.
   always @(posedge clk) begin
      if (ram_enb) ram_dob <= ramMem[ram_addrb];
   end

   task automatic checkOutput(input string name, input logic [DATA_WIDTH-1:0] actual,
                              input logic [DATA_WIDTH-1:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic expectWord(input logic [DATA_WIDTH-1:0] data, input logic last);
      expWordQ.push_back({last, data});
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
      checkOutput({tag, "_ram_enb"},   ram_enb,   0);
      checkOutput({tag, "_ram_addrb"}, ram_addrb, 0);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_out_data"},  out_data,  0);
      checkOutput({tag, "_out_last"},  out_last,  0);
      checkOutput({tag, "_busy"},      busy,      0);
      checkOutput({tag, "_done"},      done,      0);
   endtask

   // Monitor: everything is sampled mid-cycle on the falling edge.
   always @(negedge clk) begin : monitor
      logic popNow;
      logic [DATA_WIDTH:0] exp;
      cycleCount++;
      if (rst_n) begin
         popNow = out_valid && out_ready;
         if (cmd_valid && cmd_ready) acceptCount++;
         if (done) doneCount++;
         if (stalled) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data",  out_data,  heldData);
            checkOutput("stall_last",  out_last,  heldLast);
         end
         if (ram_enb) begin
            enbCount++;
            checkOutput("credit_room", (outstanding - int'(popNow)) < 2, 1);
            if (expAddrQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected_read: got addr %0d, expected no read", ram_addrb);
            end else begin
               checkOutput("read_addr", ram_addrb, expAddrQ.pop_front());
            end
         end
         if (popNow) begin
            popCount++;
            popCycleQ.push_back(cycleCount);
            if (expWordQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", out_data);
            end else begin
               exp = expWordQ.pop_front();
               checkOutput("word_data", out_data, exp[DATA_WIDTH-1:0]);
               checkOutput("word_last", out_last, exp[DATA_WIDTH]);
            end
         end
         stalled     = out_valid && !out_ready;
         heldData    = out_data;
         heldLast    = out_last;
         outstanding = outstanding + int'(ram_enb) - int'(popNow);
      end else begin
         stalled     = 1'b0;
         outstanding = 0;
      end
   end

   task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] addr, input logic [LEN_WIDTH-1:0] len);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = len;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input int base, input int budget);
      int n = 0;
      while (doneCount == base && n < budget) begin
         @(posedge clk);
         #1;
         if (bpMode) begin
            out_ready = bpPattern[bpIdx % 6];
            bpIdx++;
         end
         n++;
      end
      checkOutput("done_within_budget", doneCount != base, 1);
   endtask

   initial begin
      int d0;
      int e0;
      int a0;
      int p0;
      int n;
      for (int i = 0; i < RAM_DEPTH; i++) ramMem[i] = 64'hA0 + 64'(i) - 64'd3;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkResetOutputs("reset");
      rst_n = 1'b1;

      $display("[TB] basic burst addr=3 len=4");
      for (int a = 3; a <= 6; a++) expAddrQ.push_back(ADDR_WIDTH'(a));
      expectWord(64'hA0, 0);
      expectWord(64'hA1, 0);
      expectWord(64'hA2, 0);
      expectWord(64'hA3, 1);
      popCycleQ.delete();
      d0 = doneCount;
      applyStimulus(4'd3, 5'd4);
      checkOutput("busy_during_burst", busy, 1);
      waitDone(d0, 40);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("basic_done_once", doneCount - d0, 1);
      checkOutput("basic_busy_after", busy, 0);
      checkOutput("basic_words_left", expWordQ.size(), 0);
      checkOutput("basic_pop_count", popCycleQ.size(), 4);
      if (popCycleQ.size() == 4) checkOutput("basic_back_to_back", popCycleQ[3] - popCycleQ[0], 3);

      $display("[TB] wrap burst addr=14 len=4");
      expAddrQ.push_back(4'd14);
      expAddrQ.push_back(4'd15);
      expAddrQ.push_back(4'd0);
      expAddrQ.push_back(4'd1);
      expectWord(64'hAB, 0);
      expectWord(64'hAC, 0);
      expectWord(64'h9D, 0);
      expectWord(64'h9E, 1);
      d0 = doneCount;
      applyStimulus(4'd14, 5'd4);
      waitDone(d0, 40);
      checkOutput("wrap_words_left", expWordQ.size(), 0);
      checkOutput("wrap_addrs_left", expAddrQ.size(), 0);

      $display("[TB] backpressure burst addr=3 len=6");
      for (int a = 3; a <= 8; a++) expAddrQ.push_back(ADDR_WIDTH'(a));
      expectWord(64'hA0, 0);
      expectWord(64'hA1, 0);
      expectWord(64'hA2, 0);
      expectWord(64'hA3, 0);
      expectWord(64'hA4, 0);
      expectWord(64'hA5, 1);
      d0    = doneCount;
      bpIdx = 0;
      bpMode = 1'b1;
      applyStimulus(4'd3, 5'd6);
      waitDone(d0, 80);
      bpMode    = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_words_left", expWordQ.size(), 0);
      checkOutput("bp_addrs_left", expAddrQ.size(), 0);

      $display("[TB] zero-length command");
      d0 = doneCount;
      e0 = enbCount;
      applyStimulus(4'd5, 5'd0);
      waitDone(d0, 3);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("len0_no_reads", enbCount - e0, 0);
      checkOutput("len0_done_once", doneCount - d0, 1);
      checkOutput("len0_out_valid", out_valid, 0);

      $display("[TB] reset mid-burst");
      for (int a = 3; a <= 7; a++) expAddrQ.push_back(ADDR_WIDTH'(a));
      expectWord(64'hA0, 0);
      expectWord(64'hA1, 0);
      expectWord(64'hA2, 0);
      expectWord(64'hA3, 0);
      expectWord(64'hA4, 1);
      d0 = doneCount;
      p0 = popCount;
      applyStimulus(4'd3, 5'd5);
      n = 0;
      while (popCount < p0 + 2 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("abort_two_words_seen", popCount - p0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("abort");
      checkOutput("abort_no_done", doneCount - d0, 0);
      expWordQ.delete();
      expAddrQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expAddrQ.push_back(4'd8);
      expAddrQ.push_back(4'd9);
      expectWord(64'hA5, 0);
      expectWord(64'hA6, 1);
      d0 = doneCount;
      applyStimulus(4'd8, 5'd2);
      waitDone(d0, 40);
      checkOutput("post_abort_words_left", expWordQ.size(), 0);

      $display("[TB] cmd_valid held through a burst");
      for (int a = 10; a <= 12; a++) expAddrQ.push_back(ADDR_WIDTH'(a));
      expectWord(64'hA7, 0);
      expectWord(64'hA8, 0);
      expectWord(64'hA9, 1);
      d0 = doneCount;
      a0 = acceptCount;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = 4'd10;
      cmd_len   = 5'd3;
      waitDone(d0, 40);
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("hold_single_accept", acceptCount - a0, 1);
      checkOutput("hold_words_left", expWordQ.size(), 0);
      checkOutput("hold_addrs_left", expAddrQ.size(), 0);
      checkOutput("hold_idle_ready", cmd_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
